// File: rtl/pass_pipe_pkg.sv
// pass_pipe_pkg: shared constants, types and helpers for the pass_pipe block.
//   DEF_WIDTH / DEF_STAGES / DEF_CHANNELS : default parameter values
//   PARITY_MAX_W : widest word the parity helper accepts (callers zero-extend)
//   stage_meta_t : per-stage record flags (valid + carried parity bit); the
//                  data word itself is sized per instance by WIDTH
//   parity_of()  : even parity (XOR reduction) of a zero-extended word
package pass_pipe_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_STAGES   = 2;
  localparam int DEF_CHANNELS = 2;

  // Zero-extension does not change an XOR reduction, so one fixed-width
  // helper serves every WIDTH up to this bound.
  localparam int PARITY_MAX_W = 1024;

  typedef struct packed {
    logic valid;
    logic parity;
  } stage_meta_t;

  function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/pass_pipe_if.sv
// pass_pipe_if: multi-channel valid/ready bus around pass_pipe.
//   in_valid/in_ready/in_data    : producer side, one lane per channel
//   out_valid/out_ready/out_data : consumer side, one lane per channel
//   err                          : sticky per-channel parity error
// Data packing: channel c occupies bits [c*WIDTH +: WIDTH].
//
// Handshake: a word moves across a port on a rising clk edge where that
// channel's valid and ready are both 1. A source holding valid=1 keeps its
// data stable until the transfer; ready may depend combinationally on the
// downstream ready, valid never depends on ready.
//
// Modports: slave = the pipe itself, master = the producer/consumer pair
// that drives and drains it.
interface pass_pipe_if
  import pass_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) ();

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, err
  );

endinterface

// File: rtl/pass_stage.sv
// pass_stage: one register slot of a single channel with valid/ready.
//   clk, rst           : clock, synchronous active-high reset
//   up_valid/up_ready  : upstream handshake, up_data is the word offered
//   dn_valid/dn_ready  : downstream handshake, dn_data is the word held
// The slot accepts when empty or when its word leaves in the same cycle,
// so a chain of these runs at one word per clock with no bubbles. The
// ready path is combinational; valid and data are registered.
module pass_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  output logic          dn_valid,
  input  logic          dn_ready,
  output logic [DW-1:0] dn_data
);

  logic          vld;
  logic [DW-1:0] dat;

  assign up_ready = !vld || dn_ready;
  assign dn_valid = vld;
  assign dn_data  = dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (up_ready) begin
      vld <= up_valid;
      // Data only moves with a real word; an empty slot keeps old data.
      if (up_valid) dat <= up_data;
    end
  end

endmodule

// File: rtl/pass_pipe.sv
// pass_pipe: CHANNELS independent lanes, each a chain of STAGES pass_stage
// slots carrying WIDTH-bit words with valid/ready flow control.
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset, flushes every in-flight word
//   bus : pass_pipe_if slave modport (in_*, out_*, err)
// STAGES = 0 gives a plain wire-through per lane.
// Optional feature macro: PASS_PIPE_PARITY_EN. When defined each slot
// carries a parity bit generated at the input; a mismatch seen on an output
// transfer sets that channel's err bit until reset. When undefined, err is 0.
module pass_pipe
  import pass_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STAGES   = DEF_STAGES,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic        clk,
  input  logic        rst,
  pass_pipe_if.slave  bus
);

`ifdef PASS_PIPE_PARITY_EN
  localparam int DW = WIDTH + 1;  // parity rides in the MSB of each slot
`else
  localparam int DW = WIDTH;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    if (STAGES == 0) begin : g_comb
      assign bus.out_valid[c]               = bus.in_valid[c];
      assign bus.out_data[c*WIDTH +: WIDTH] = bus.in_data[c*WIDTH +: WIDTH];
      assign bus.in_ready[c]                = bus.out_ready[c];
      assign bus.err[c]                     = 1'b0;
    end else begin : g_pipe
      // Index k is the link into slot k; index STAGES is the output port.
      logic [STAGES:0] v;
      logic [STAGES:0] r;
      logic [DW-1:0]   d [STAGES+1];

      assign v[0]            = bus.in_valid[c];
      assign bus.in_ready[c] = r[0];
      assign r[STAGES]       = bus.out_ready[c];
      assign bus.out_valid[c] = v[STAGES];
      assign bus.out_data[c*WIDTH +: WIDTH] = d[STAGES][WIDTH-1:0];

`ifdef PASS_PIPE_PARITY_EN
      assign d[0] = {parity_of(PARITY_MAX_W'(bus.in_data[c*WIDTH +: WIDTH])),
                     bus.in_data[c*WIDTH +: WIDTH]};
`else
      assign d[0] = bus.in_data[c*WIDTH +: WIDTH];
`endif

      for (genvar k = 0; k < STAGES; k++) begin : g_st
        pass_stage #(.DW(DW)) u_stage (
          .clk      (clk),
          .rst      (rst),
          .up_valid (v[k]),
          .up_ready (r[k]),
          .up_data  (d[k]),
          .dn_valid (v[k+1]),
          .dn_ready (r[k+1]),
          .dn_data  (d[k+1])
        );
      end

`ifdef PASS_PIPE_PARITY_EN
      logic err_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          err_q <= 1'b0;
        end else if (v[STAGES] && r[STAGES] &&
                     (parity_of(PARITY_MAX_W'(d[STAGES][WIDTH-1:0])) != d[STAGES][WIDTH])) begin
          err_q <= 1'b1;
        end
      end
      assign bus.err[c] = err_q;
`else
      assign bus.err[c] = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pass_pipe.sv
// tb_pass_pipe: directed bench for pass_pipe at default parameters
// (WIDTH=32, STAGES=2, CHANNELS=2). Accepted input words are queued per
// channel; a negedge monitor pops and compares every output transfer.
// Directed checks cover reset state, latency, ready behaviour under
// backpressure, full-pipe pass-through and mid-stream reset. With
// PASS_PIPE_PARITY_EN defined a corrupted slot must raise err[0] only.
module tb_pass_pipe;

  localparam int W = 32;
  localparam int S = 2;
  localparam int C = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pass_pipe_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  pass_pipe #(.WIDTH(W), .STAGES(S), .CHANNELS(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt[C];
  int first_cyc[C];
  int last_cyc[C];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_rx();
    for (int i = 0; i < C; i++) begin
      rx_cnt[i] = 0;
      first_cyc[i] = 0;
      last_cyc[i] = 0;
    end
  endtask

  // Monitor: inputs accepted this cycle are queued first, then any output
  // transfer this cycle is compared against the head of its queue.
  always @(negedge clk) begin
    logic [W-1:0] got;
    if (!rst) begin
      if (bus.in_valid[0] && bus.in_ready[0]) exp_q0.push_back(bus.in_data[W-1:0]);
      if (bus.in_valid[1] && bus.in_ready[1]) exp_q1.push_back(bus.in_data[2*W-1:W]);
      for (int ch = 0; ch < C; ch++) begin
        if (bus.out_valid[ch] && bus.out_ready[ch]) begin
          got = bus.out_data[ch*W +: W];
          rx_cnt[ch]++;
          if (rx_cnt[ch] == 1) first_cyc[ch] = cyc;
          last_cyc[ch] = cyc;
          if (ch == 0) begin
            if (exp_q0.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_out ch0: got 0x%0h, expected no word", got);
            end else check("ch0_data", got, exp_q0.pop_front());
          end else begin
            if (exp_q1.size() == 0) begin
              n_checks++;
              $display("FAIL unexpected_out ch1: got 0x%0h, expected no word", got);
            end else check("ch1_data", got, exp_q1.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] v, input logic [W-1:0] d1, input logic [W-1:0] d0);
    bus.in_valid = v;
    bus.in_data  = {d1, d0};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic ready_ok;
  logic [W:0] tmp_slot;

  initial begin
    bus.out_ready = 2'b11;
    set_in(2'b00, '0, '0);
    clear_rx();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd3);
    check("rst_err", 64'(bus.err), 64'd0);
    step();

    // Single word, latency STAGES=2 cycles from in_valid high
    clear_rx();
    set_in(2'b01, '0, 32'hDEADBEEF);
    @(negedge clk);
    check("lat_c0_valid", 64'(bus.out_valid[0]), 64'd0);
    step();
    set_in(2'b00, '0, '0);
    @(negedge clk);
    check("lat_c1_valid", 64'(bus.out_valid[0]), 64'd0);
    step();
    @(negedge clk);
    check("lat_c2_valid", 64'(bus.out_valid[0]), 64'd1);
    check("lat_c2_data", 64'(bus.out_data[W-1:0]), 64'hDEADBEEF);
    check("lat_ch1_idle", 64'(bus.out_valid[1]), 64'd0);
    step();
    drain();
    check("lat_count", 64'(rx_cnt[0] + rx_cnt[1]), 64'd1);

    // Continuous stream 0..99 on both channels
    clear_rx();
    ready_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_in(2'b11, W'(i), W'(i));
      @(negedge clk);
      if (bus.in_ready != 2'b11) ready_ok = 1'b0;
      step();
    end
    set_in(2'b00, '0, '0);
    drain();
    check("stream_ready_high", 64'(ready_ok), 64'd1);
    check("stream_cnt0", 64'(rx_cnt[0]), 64'd100);
    check("stream_cnt1", 64'(rx_cnt[1]), 64'd100);
    check("stream_gapless0", 64'(last_cyc[0] - first_cyc[0]), 64'd99);
    check("stream_gapless1", 64'(last_cyc[1] - first_cyc[1]), 64'd99);

    // Backpressure on ch1 only
    clear_rx();
    bus.out_ready = 2'b01;
    set_in(2'b11, 32'h1, 32'h10);
    @(negedge clk);
    check("bp_ready_empty", 64'(bus.in_ready), 64'd3);
    step();
    set_in(2'b11, 32'h2, 32'h11);
    @(negedge clk);
    check("bp_ready_one", 64'(bus.in_ready[1]), 64'd1);
    step();
    set_in(2'b11, 32'h3, 32'h12);
    @(negedge clk);
    check("bp_full_ready", 64'(bus.in_ready), 64'd1);
    step();
    set_in(2'b10, 32'h3, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_ready", 64'(bus.in_ready[1]), 64'd0);
      check("bp_hold_valid", 64'(bus.out_valid[1]), 64'd1);
      check("bp_hold_data", 64'(bus.out_data[2*W-1:W]), 64'h1);
      step();
    end
    bus.out_ready = 2'b11;
    @(negedge clk);
    check("bp_release_ready", 64'(bus.in_ready[1]), 64'd1);
    step();
    set_in(2'b00, '0, '0);
    drain();
    check("bp_cnt0", 64'(rx_cnt[0]), 64'd3);
    check("bp_cnt1", 64'(rx_cnt[1]), 64'd3);

    // Full pipe on ch0, then accept and emit together each cycle
    clear_rx();
    bus.out_ready = 2'b10;
    for (int j = 0; j < 2; j++) begin
      set_in(2'b01, '0, W'(32'hA0 + j));
      step();
    end
    bus.out_ready = 2'b11;
    for (int j = 2; j < 6; j++) begin
      set_in(2'b01, '0, W'(32'hA0 + j));
      @(negedge clk);
      check("full_simul_ready", 64'(bus.in_ready[0]), 64'd1);
      step();
    end
    set_in(2'b00, '0, '0);
    drain();
    check("full_cnt", 64'(rx_cnt[0]), 64'd6);
    check("full_gapless", 64'(last_cyc[0] - first_cyc[0]), 64'd5);

    // Reset with words in flight: they must never appear
    bus.out_ready = 2'b00;
    set_in(2'b11, 32'hC0, 32'hB0);
    step();
    set_in(2'b11, 32'hC1, 32'hB1);
    step();
    set_in(2'b00, '0, '0);
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    step();
    rst = 1'b0;
    clear_rx();
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd3);
    step();
    bus.out_ready = 2'b11;
    for (int i = 0; i < 5; i++) step();
    check("flush_no_output", 64'(rx_cnt[0] + rx_cnt[1]), 64'd0);

`ifdef PASS_PIPE_PARITY_EN
    // Corrupt bit 0 of the last ch0 slot while it is held
    clear_rx();
    bus.out_ready = 2'b10;
    set_in(2'b11, 32'h7, 32'h5);
    step();
    set_in(2'b00, '0, '0);
    step();
    tmp_slot = dut.g_ch[0].g_pipe.g_st[1].u_stage.dat;
    force dut.g_ch[0].g_pipe.g_st[1].u_stage.dat = tmp_slot ^ 33'd1;
    @(negedge clk);
    check("par_err_before", 64'(bus.err), 64'd0);
    release dut.g_ch[0].g_pipe.g_st[1].u_stage.dat;
    if (exp_q0.size() != 0) exp_q0[0] = exp_q0[0] ^ 32'h1;
    step();
    bus.out_ready = 2'b11;
    step();
    @(negedge clk);
    check("par_err_set", 64'(bus.err), 64'd1);
    step();
    step();
    @(negedge clk);
    check("par_err_sticky", 64'(bus.err), 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("par_err_cleared", 64'(bus.err), 64'd0);
    step();
`else
    tmp_slot = '0;
    @(negedge clk);
    check("err_tied_low", 64'(bus.err), 64'(tmp_slot));
    step();
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pass_pipe.md
# pass_pipe

Parametrised, multi-channel registered pass-through with valid/ready flow control. It is the pipelined successor of our plain 32-bit combinational word pass-through: each of CHANNELS independent lanes carries WIDTH-bit words through STAGES register stages at full throughput. It sits between producer and consumer blocks wherever a timing cut or backpressure boundary is needed, and optionally tracks end-to-end parity integrity.

## Interface
- WIDTH, 32, data bits per channel (>=1)
- STAGES, 2, register stages per channel (0 = combinational pass-through)
- CHANNELS, 2, independent lanes (>=1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  CHANNELS  producer word valid, per channel
- in_ready  out  CHANNELS  block can accept, per channel
- in_data  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  word available, per channel
- out_ready  in  CHANNELS  consumer accepts, per channel
- out_data  out  CHANNELS*WIDTH  same packing as in_data
- err  out  CHANNELS  sticky parity error, per channel (0 when PASS_PIPE_PARITY_EN undefined)

## Operation
- Channels fully independent; no shared state, no arbitration.
- Transfer on a port occurs when valid & ready are both 1 on a rising edge.
- Each stage holds one word plus a valid bit. Stage k accepts when empty or when stage k+1 accepts in the same cycle: ready_k = !valid_k | ready_{k+1}. Last stage uses out_ready.
- Ready chain is combinational from out_ready to in_ready (no skid buffer); valid/data are registered.
- Words leave in arrival order; no drop, duplication or reordering per channel.
- Stage with valid=1 and downstream not ready holds its data unchanged.
- STAGES=0: out_valid=in_valid, out_data=in_data, in_ready=out_ready, no registers; err stays 0.
- Data unaltered bit-for-bit; no width conversion.

## Timing
- Reset: all stage valid bits 0, out_valid=0, err=0, in_ready=1 (all stages empty); stage data registers reset to 0.
- Latency: word accepted at edge N appears on out_valid/out_data after edge N+STAGES-1 (visible in cycle following edge N+STAGES-1), given no backpressure; i.e. STAGES cycles from in_valid high to out_valid high.
- Throughput: one word per clock per channel under continuous valid & ready.
- Full: all STAGES stages valid and out_ready=0 -> in_ready=0; in_data ignored.
- Simultaneous: full pipe with out_ready=1 -> in_ready=1, accept and emit in same cycle, occupancy constant.
- rst asserted mid-stream: all in-flight words discarded at that edge; err cleared; rst has priority over any transfer.
- out_valid never deasserts without a transfer except on reset.

## Configuration
- PASS_PIPE_PARITY_EN defined: each stage carries one extra parity bit (XOR of WIDTH data bits) generated at input. On every output transfer, recomputed parity compared with carried bit; mismatch sets err[c], held until rst.
- Undefined: no parity storage, err tied to 0.

## Structure
- Package pass_pipe_pkg: default WIDTH/STAGES/CHANNELS constants, parity function, typedef for stage record (valid, data, parity).
- One sub-module pass_stage: single-channel, single-stage register with valid/ready; pass_pipe generates CHANNELS x STAGES instances.

## Test plan
- Reset then single word 0xDEADBEEF on ch0, out_ready=1 -> out_data[31:0]=0xDEADBEEF exactly STAGES(=2) cycles later, ch1 out_valid stays 0.
- Stream 0..99 on both channels, out_ready=1 continuous -> 100 words per channel, in order, one per cycle, in_ready never 0.
- out_ready=0 on ch1, push 3 words -> ch1 in_ready=0 after 2 accepted (0x1,0x2 held), ch0 unaffected; release -> 0x1,0x2,0x3 in order.
- Full pipe, out_ready=1, in_valid=1 same cycle -> one in and one out that edge, out sequence gapless.
- rst pulse with 2 words in flight -> out_valid=0 next cycle, those words never emitted, in_ready=1.
- PASS_PIPE_PARITY_EN: force flip of bit 0 in stage 1 data of ch0 -> err[0]=1 on its output transfer, stays 1 until rst; err[1]=0.
